// File: rtl/soc_system_seven_seg_pkg.sv
// Shared definitions for the six-digit seven-segment controller.
// Holds the register map, CTRL field layout, the blank pattern and the
// hex-to-segment decode table (active-low, bit0 = a .. bit6 = g).
// Optional build macro used by the controller: SEVEN_SEG_SCROLL_EN.
package soc_system_seven_seg_pkg;

   localparam int unsigned NUM_DIGITS = 6;

   localparam logic [2:0] ADDR_DIGITS    = 3'd0;
   localparam logic [2:0] ADDR_CTRL      = 3'd1;
   localparam logic [2:0] ADDR_BLINK_DIV = 3'd2;
   localparam logic [2:0] ADDR_STATUS    = 3'd3;

   localparam int unsigned CTRL_BLANK_LSB  = 0;
   localparam int unsigned CTRL_BLINK_LSB  = 8;
   localparam int unsigned CTRL_ENABLE_BIT = 16;
   localparam int unsigned CTRL_SCROLL_BIT = 17;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n is the segment pattern for nibble value n.
   localparam logic [15:0][6:0] SEG_DECODE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic       scroll;
      logic       enable;
      logic [5:0] blink;
      logic [5:0] blank;
   } ctrl_t;

endpackage

// File: rtl/soc_system_seven_seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
// Ports: nibble - hex value 0..F; seg - segment pattern, bit0 = a .. bit6 = g.
module soc_system_seven_seg_decode
   import soc_system_seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DECODE[nibble];
   end

endmodule

// File: rtl/soc_system_seven_seg_ctrl.sv
// Avalon-MM slave driving six active-low seven-segment digits.
// Registers: DIGITS (0), CTRL (1), BLINK_DIV (2), STATUS (3, read-only).
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     - Avalon-MM write side (zero wait states)
//   readdata               - combinational read mux on address
//   hex_out                - registered segments, digit i at [7i+6:7i]
// Build macro SEVEN_SEG_SCROLL_EN adds CTRL[17] and the rotating display.
module soc_system_seven_seg_ctrl
   import soc_system_seven_seg_pkg::*;
#(
   parameter int unsigned DEFAULT_BLINK_DIV = 25_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [41:0] hex_out
);

   logic        wr_en, wr_digits, wr_ctrl, wr_div;
   logic [23:0] digits_q;
   ctrl_t       ctrl_q, ctrl_wdata;
   logic [25:0] div_q, cnt_q, term;
   logic        phase_q, tick;
   logic [2:0]  offset_q;
   logic [41:0] hex_q, hex_d;
   logic [5:0][3:0] nib;
   logic [5:0][6:0] seg_dec;
   int unsigned src;

   assign wr_en     = chipselect && !write_n;
   assign wr_digits = wr_en && (address == ADDR_DIGITS);
   assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
   assign wr_div    = wr_en && (address == ADDR_BLINK_DIV);

   // A divider of 0 is treated as 1 so the tick fires every cycle.
   assign term = (div_q == '0) ? '0 : div_q - 26'd1;
   assign tick = (cnt_q == term);

   always_comb begin
      ctrl_wdata.blank  = writedata[CTRL_BLANK_LSB +: 6];
      ctrl_wdata.blink  = writedata[CTRL_BLINK_LSB +: 6];
      ctrl_wdata.enable = writedata[CTRL_ENABLE_BIT];
`ifdef SEVEN_SEG_SCROLL_EN
      ctrl_wdata.scroll = writedata[CTRL_SCROLL_BIT];
`else
      ctrl_wdata.scroll = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digits_q <= '0;
         ctrl_q   <= '0;
         div_q    <= DEFAULT_BLINK_DIV[25:0];
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         if (wr_digits) digits_q <= writedata[23:0];
         if (wr_ctrl)   ctrl_q   <= ctrl_wdata;
         // A divider write restarts the blink period and beats a coincident tick.
         if (wr_div) begin
            div_q   <= writedata[25:0];
            cnt_q   <= '0;
            phase_q <= 1'b0;
         end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q + 26'd1;
         end
      end
   end

`ifdef SEVEN_SEG_SCROLL_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         offset_q <= '0;
      end else if (wr_ctrl && !writedata[CTRL_SCROLL_BIT]) begin
         offset_q <= '0;
      end else if (tick && !wr_div && ctrl_q.scroll) begin
         offset_q <= (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
      end
   end
`else
   assign offset_q = 3'd0;
`endif

   // Physical digit i shows stored nibble (i + offset) mod 6: rotate left.
   always_comb begin
      nib = '0;
      src = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         src = i + int'(offset_q);
         if (src >= NUM_DIGITS) src = src - NUM_DIGITS;
         nib[i] = digits_q[4*src +: 4];
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      soc_system_seven_seg_decode u_decode (
         .nibble (nib[g]),
         .seg    (seg_dec[g])
      );
   end

   // Masks act on physical positions, after rotation.
   always_comb begin
      hex_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!ctrl_q.enable || ctrl_q.blank[i] || (ctrl_q.blink[i] && phase_q)) begin
            hex_d[7*i +: 7] = SEG_BLANK;
         end else begin
            hex_d[7*i +: 7] = seg_dec[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hex_q <= '1;
      else          hex_q <= hex_d;
   end

   assign hex_out = hex_q;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DIGITS:    readdata[23:0] = digits_q;
         ADDR_CTRL: begin
            readdata[CTRL_BLANK_LSB +: 6] = ctrl_q.blank;
            readdata[CTRL_BLINK_LSB +: 6] = ctrl_q.blink;
            readdata[CTRL_ENABLE_BIT]     = ctrl_q.enable;
            readdata[CTRL_SCROLL_BIT]     = ctrl_q.scroll;
         end
         ADDR_BLINK_DIV: readdata[25:0] = div_q;
         ADDR_STATUS:    readdata[3:0]  = {offset_q, phase_q};
         default:        readdata = '0;
      endcase
   end

   logic unused_wdata;
   assign unused_wdata = ^{writedata[31:26], writedata[17], writedata[15:14], writedata[7:6]};

endmodule

// File: tb/tb_soc_system_seven_seg_ctrl.sv
module tb_soc_system_seven_seg_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [41:0] hex_out;

   soc_system_seven_seg_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .hex_out    (hex_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // Reference state: register contents plus the edges at which timing restarted.
   logic [23:0] m_digits;
   logic [5:0]  m_blank, m_blink;
   logic        m_enable, m_scroll;
   int          m_div, div_edge, scroll_edge;

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
         4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
         4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
         4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   // Number of blink periods completed by the end of edge e.
   function automatic int ticks_at(input int e);
      int d;
      d = (m_div == 0) ? 1 : m_div;
      return (e - div_edge) / d;
   endfunction

   function automatic bit phase_at(input int e);
      return (ticks_at(e) % 2) == 1;
   endfunction

   function automatic int offset_at(input int e);
`ifdef SEVEN_SEG_SCROLL_EN
      if (m_scroll) return (ticks_at(e) - ticks_at(scroll_edge)) % 6;
`endif
      return 0;
   endfunction

   function automatic logic [41:0] ref_hex(input int e);
      logic [41:0] h;
      int off;
      bit ph;
      off = offset_at(e);
      ph = phase_at(e);
      for (int i = 0; i < 6; i++) begin
         if (!m_enable || m_blank[i] || (m_blink[i] && ph)) h[7*i +: 7] = 7'h7F;
         else h[7*i +: 7] = ref_seg(m_digits[4*((i + off) % 6) +: 4]);
      end
      return h;
   endfunction

   task automatic model_reset();
      m_digits = '0; m_blank = '0; m_blink = '0; m_enable = 1'b0; m_scroll = 1'b0;
      m_div = 25_000_000; div_edge = cyc; scroll_edge = cyc;
   endtask

   // Write lands on the edge two edges after the negedge it is called from.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      case (a)
         3'd0: m_digits = d[23:0];
         3'd1: begin
            m_blank = d[5:0]; m_blink = d[13:8]; m_enable = d[16];
`ifdef SEVEN_SEG_SCROLL_EN
            if (!d[17]) m_scroll = 1'b0;
            else if (!m_scroll) begin m_scroll = 1'b1; scroll_edge = cyc; end
`endif
         end
         3'd2: begin m_div = int'(d[25:0]); div_edge = cyc; end
         default: ;
      endcase
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Compares hex_out and STATUS against the model for n consecutive cycles.
   task automatic run_check(input string name, input int n);
      logic [31:0] r;
      logic [41:0] eh;
      logic [31:0] es;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         eh = ref_hex(cyc - 1);
         total++;
         if (hex_out !== eh) begin
            bad++;
            $display("FAIL %s hex cyc=%0d: got %h expected %h", name, cyc, hex_out, eh);
         end
         rd(3'd3, r);
         es = {28'd0, 3'(offset_at(cyc)), phase_at(cyc)};
         total++;
         if (r !== es) begin
            bad++;
            $display("FAIL %s status cyc=%0d: got %h expected %h", name, cyc, r, es);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      repeat (3) @(negedge clk);
      total++;
      if (hex_out !== 42'h3FF_FFFF_FFFF) begin
         bad++; $display("FAIL reset_hex: got %h expected %h", hex_out, 42'h3FF_FFFF_FFFF);
      end
      rd(3'd2, r);
      total++;
      if (r !== 32'd25_000_000) begin
         bad++; $display("FAIL reset_div: got %0d expected %0d", r, 25_000_000);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      rd(3'd1, r);
      total++;
      if (r !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h expected 0", r); end
      rd(3'd3, r);
      total++;
      if (r !== 32'd0) begin bad++; $display("FAIL reset_status: got %h expected 0", r); end
      rd(3'd0, r);
      total++;
      if (r !== 32'd0) begin bad++; $display("FAIL reset_digits: got %h expected 0", r); end
      run_check("after_reset", 3);
   endtask

   task automatic test_decode();
      logic [6:0] exp_d [6];
      exp_d = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      wr(3'd0, 32'h00FE_DCBA);
      wr(3'd1, 32'h0001_0000);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (hex_out[7*i +: 7] !== exp_d[i]) begin
            bad++;
            $display("FAIL decode digit%0d: got %h expected %h", i, hex_out[7*i +: 7], exp_d[i]);
         end
      end
   endtask

   task automatic test_blank_enable();
      logic [41:0] e1;
      e1 = {7'h0E, 7'h06, 7'h21, 7'h7F, 7'h03, 7'h7F};
      wr(3'd1, 32'h0001_0005);
      @(negedge clk);
      total++;
      if (hex_out !== e1) begin bad++; $display("FAIL blank_mask: got %h expected %h", hex_out, e1); end
      wr(3'd1, 32'h0000_0000);
      @(negedge clk);
      total++;
      if (hex_out !== 42'h3FF_FFFF_FFFF) begin
         bad++; $display("FAIL disable: got %h expected %h", hex_out, 42'h3FF_FFFF_FFFF);
      end
   endtask

   task automatic test_registers();
      logic [31:0] r;
      wr(3'd0, 32'hFFFF_FFFF);
      rd(3'd0, r);
      total++;
      if (r !== 32'h00FF_FFFF) begin bad++; $display("FAIL digits_mask: got %h expected 00ffffff", r); end
      wr(3'd3, 32'hFFFF_FFFF);
      rd(3'd3, r);
      total++;
      if (r !== {28'd0, 3'(offset_at(cyc)), phase_at(cyc)}) begin
         bad++; $display("FAIL status_ro: got %h expected %h", r, {28'd0, 3'(offset_at(cyc)), phase_at(cyc)});
      end
      rd(3'd5, r);
      total++;
      if (r !== 32'd0) begin bad++; $display("FAIL unmapped: got %h expected 0", r); end
   endtask

   task automatic test_blink();
      logic [31:0] r;
      int k, t;
      wr(3'd0, $urandom & 32'h00FF_FFFF);
      wr(3'd1, 32'h0001_0200);
      wr(3'd2, 32'd3);
      run_check("blink", 14);
      // Land a divider write exactly on a tick edge while phase is 0.
      k = (cyc + 1 - div_edge) / 3 + 1;
      if (k % 2 == 0) k++;
      t = div_edge + 3 * k;
      while (cyc < t - 2) @(negedge clk);
      wr(3'd2, 32'd3);
      rd(3'd3, r);
      total++;
      if (r[0] !== 1'b0 || cyc != t) begin
         bad++; $display("FAIL blink_tick_write: phase got %0d expected 0 (edge %0d vs %0d)", r[0], cyc, t);
      end
      run_check("blink_restart", 10);
   endtask

   task automatic test_random();
      logic [31:0] c, r;
      for (int it = 0; it < 6; it++) begin
         wr(3'd1, 32'd0);
         wr(3'd0, $urandom & 32'h00FF_FFFF);
         wr(3'd2, $urandom_range(0, 4));
         c = $urandom & 32'h0002_3F3F;
         if ($urandom_range(0, 3) != 0) c[16] = 1'b1;
         wr(3'd1, c);
         rd(3'd1, r);
         total++;
`ifdef SEVEN_SEG_SCROLL_EN
         if (r !== c) begin bad++; $display("FAIL rand_ctrl_rb: got %h expected %h", r, c); end
`else
         if (r !== (c & 32'h0001_3F3F)) begin
            bad++; $display("FAIL rand_ctrl_rb: got %h expected %h", r, c & 32'h0001_3F3F);
         end
`endif
         run_check("random", 15);
      end
   endtask

`ifdef SEVEN_SEG_SCROLL_EN
   task automatic test_scroll();
      logic [31:0] r;
      wr(3'd1, 32'd0);
      wr(3'd0, 32'h0054_3210);
      wr(3'd2, 32'd2);
      wr(3'd1, 32'h0003_0000);
      run_check("scroll", 16);
      wr(3'd1, 32'h0001_0000);
      rd(3'd3, r);
      total++;
      if (r[3:1] !== 3'd0) begin bad++; $display("FAIL scroll_clear: offset got %0d expected 0", r[3:1]); end
      run_check("scroll_off", 4);
   endtask
`else
   task automatic test_scroll();
      logic [31:0] r;
      wr(3'd1, 32'd0);
      wr(3'd0, 32'h0054_3210);
      wr(3'd2, 32'd2);
      wr(3'd1, 32'h0003_0000);
      rd(3'd1, r);
      total++;
      if (r !== 32'h0001_0000) begin bad++; $display("FAIL no_scroll_rb: got %h expected 00010000", r); end
      run_check("no_scroll", 40);
   endtask
`endif

   task automatic test_reset_mid();
      logic [31:0] r;
      wr(3'd0, 32'h0012_3456);
      wr(3'd2, 32'd2);
      wr(3'd1, 32'h0003_0100);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (hex_out !== 42'h3FF_FFFF_FFFF) begin
         bad++; $display("FAIL midreset_hex: got %h expected %h", hex_out, 42'h3FF_FFFF_FFFF);
      end
      rd(3'd2, r);
      total++;
      if (r !== 32'd25_000_000) begin bad++; $display("FAIL midreset_div: got %0d expected 25000000", r); end
      rd(3'd3, r);
      total++;
      if (r !== 32'd0) begin bad++; $display("FAIL midreset_status: got %h expected 0", r); end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      run_check("post_midreset", 3);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_blank_enable();
      test_registers();
      test_blink();
      test_scroll();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
